// File: rtl/spi_slave_pkg.sv
// -----------------------------------------------------------------------------
// spi_slave_pkg
//   Shared definitions for the SPI slave front end: byte and bit-counter
//   widths plus the controller state encoding.
// -----------------------------------------------------------------------------
package spi_slave_pkg;

    localparam int SPI_BYTE_W    = 8;
    localparam int SPI_BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,   // after reset, until chip select is seen high
        S_IDLE   = 2'd1,   // deselected
        S_ACTIVE = 2'd2    // frame in progress, shifting
    } spi_state_t;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
//   Brings one asynchronous pin into the sys_clk domain through a
//   SYNC_STAGES-deep flop chain and flags its edges.
//
//   Ports:
//     sys_clk  in   system clock
//     rst      in   synchronous, active-high reset
//     pin      in   asynchronous input
//     level    out  synchronised level (last chain flop)
//     rise     out  registered one-cycle pulse on a synchronised 0->1
//     fall     out  registered one-cycle pulse on a synchronised 1->0
//
//   The chain resets to 0 so that a pin already low at reset time produces
//   no edge and a pin already high produces only a rise.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    assign level = chain[SYNC_STAGES-1];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            prev  <= level;
            rise  <= level & ~prev;
            fall  <= ~level & prev;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   Mode-0 (CPOL=0, CPHA=0) SPI slave. Synchronises the SPI pins into
//   sys_clk, deserialises MOSI into bytes for the CSR block and serialises
//   the CSR response byte onto MISO.
//
//   Ports:
//     sys_clk     in   system clock, rising edge
//     rst         in   synchronous, active-high reset
//     spi_sclk    in   SPI clock (async)
//     spi_cs_n    in   chip select, active low (async)
//     spi_mosi    in   serial data in (async)
//     spi_miso    out  serial data out, 0 while deselected
//     rx_data     out  last complete received byte
//     data_rdy    out  one-cycle pulse when rx_data updates
//     tx_data     in   response byte from the CSR
//     data_latch  in   captures tx_data into the transmit buffer
//
//   Build option:
//     SPI_SLAVE_LSB_FIRST_EN  when defined, both directions shift LSB first.
// -----------------------------------------------------------------------------
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  data_rdy,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  data_latch
);

    localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = '1;

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .sys_clk (sys_clk),
        .rst     (rst),
        .pin     (spi_sclk),
        .level   (sclk_level),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .sys_clk (sys_clk),
        .rst     (rst),
        .pin     (spi_cs_n),
        .level   (cs_level),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    // MOSI goes through the same depth as SCLK, so when sclk_rise fires the
    // synced level is the bit the master presented before that edge.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .sys_clk (sys_clk),
        .rst     (rst),
        .pin     (spi_mosi),
        .level   (mosi_level),
        .rise    (mosi_rise),
        .fall    (mosi_fall)
    );

    // Synchroniser outputs this block has no use for.
    logic unused_sync;
    assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall};

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    spi_state_t state, state_nxt;

    always_ff @(posedge sys_clk) begin
        if (rst) state <= S_WAIT;
        else     state <= state_nxt;
    end

    // S_WAIT only leaves on a high chip select, so a reset landing inside a
    // frame discards the rest of it rather than joining mid-byte.
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:   if (cs_level) state_nxt = S_IDLE;
            S_IDLE:   if (cs_fall)  state_nxt = S_ACTIVE;
            S_ACTIVE: if (cs_rise)  state_nxt = S_IDLE;
            default:                state_nxt = S_WAIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [SPI_BIT_CNT_W-1:0] bit_cnt;
    logic [SPI_BYTE_W-1:0]    rx_shift, rx_next;
    logic [SPI_BYTE_W-1:0]    tx_shift, tx_shifted, tx_load;
    logic [SPI_BYTE_W-1:0]    tx_buf;
    logic                     reload;
    logic                     miso_bit;
    logic                     entering;

    assign entering = (state == S_IDLE) && cs_fall;

    // A latch in the same cycle as a shift-register load bypasses tx_buf.
    assign tx_load = data_latch ? tx_data : tx_buf;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next    = {mosi_level, rx_shift[SPI_BYTE_W-1:1]};
    assign tx_shifted = {1'b0, tx_shift[SPI_BYTE_W-1:1]};
    assign miso_bit   = tx_shift[0];
`else
    assign rx_next    = {rx_shift[SPI_BYTE_W-2:0], mosi_level};
    assign tx_shifted = {tx_shift[SPI_BYTE_W-2:0], 1'b0};
    assign miso_bit   = tx_shift[SPI_BYTE_W-1];
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            data_rdy <= 1'b0;
            tx_shift <= '0;
            tx_buf   <= '0;
            reload   <= 1'b0;
        end else begin
            data_rdy <= 1'b0;
            if (data_latch) tx_buf <= tx_data;

            if (entering) begin
                bit_cnt  <= '0;
                tx_shift <= tx_load;
                reload   <= 1'b0;
            end else if (state == S_ACTIVE) begin
                if (cs_rise) begin
                    // Deselect mid-byte: drop the partial byte.
                    bit_cnt <= '0;
                    reload  <= 1'b0;
                end else begin
                    if (sclk_rise) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            rx_data  <= rx_next;
                            data_rdy <= 1'b1;
                            reload   <= 1'b1;
                        end
                    end
                    // The falling edge after a completed byte puts the first
                    // bit of the next response on MISO.
                    if (sclk_fall) begin
                        if (reload) begin
                            tx_shift <= tx_load;
                            reload   <= 1'b0;
                        end else begin
                            tx_shift <= tx_shifted;
                        end
                    end
                end
            end
        end
    end

    assign spi_miso = (state == S_ACTIVE) ? miso_bit : 1'b0;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;
    import spi_slave_pkg::*;

    localparam int SS   = 2;
    localparam int HALF = 4;   // sclk half period in sys_clk cycles (f_sys/8)

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       data_latch = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       spi_miso;
    logic [7:0] rx_data;
    logic       data_rdy;

    int tests = 0, fails = 0;
    int cyc = 0, rdy_cnt = 0, rdy_cyc = 0, rise_cyc = 0;
    int latch_req = 0, latch_done = 0, auto_at = -1;
    logic [7:0] latch_val = 8'h00, auto_val = 8'h00;
    logic [7:0] exp_q[$];

    typedef struct {
        bit         do_latch;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
    } vec_t;
    vec_t vecs[5];

    spi_slave #(.SYNC_STAGES(SS)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .rx_data    (rx_data),
        .data_rdy   (data_rdy),
        .tx_data    (tx_data),
        .data_latch (data_latch)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Master shifts n bits of b; returns the MISO bits sampled on each rise.
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            int idx;
`ifdef SPI_SLAVE_LSB_FIRST_EN
            idx = i;
`else
            idx = 7 - i;
`endif
            spi_mosi = b[idx];
            tick(HALF);
            spi_sclk = 1'b1;
            rise_cyc = cyc;
            r[idx]   = spi_miso;
            tick(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
        exp_q.push_back(b);
        spi_bits(b, 8, r);
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        tick(2 * HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic csr_latch(input logic [7:0] v);
        latch_val = v;
        latch_req++;
        tick(3);
    endtask

    initial begin
        logic [7:0] r, r1, r2, r3;
        int n0;

        vecs[0] = '{1'b1, 8'hFF, 8'h00, 8'hFF};
        vecs[1] = '{1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[2] = '{1'b1, 8'h96, 8'h69, 8'h96};
        vecs[3] = '{1'b0, 8'h00, 8'hC3, 8'h96};   // no latch: stale byte resent
        vecs[4] = '{1'b1, 8'h01, 8'h80, 8'h01};

        // CSR model: drives data_latch, checks every data_rdy against the queue.
        fork
            forever begin
                logic [7:0] e;
                @(posedge sys_clk);
                #1;
                data_latch = 1'b0;
                if (latch_req != latch_done) begin
                    data_latch = 1'b1;
                    tx_data    = latch_val;
                    latch_done++;
                end
                if (data_rdy) begin
                    rdy_cnt++;
                    rdy_cyc = cyc;
                    if (rdy_cnt == auto_at) begin
                        data_latch = 1'b1;
                        tx_data    = auto_val;
                    end
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL rx_unexpected: data_rdy with rx_data=0x%02h, none expected", rx_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (rx_data !== e) begin
                            fails++;
                            $display("FAIL rx_byte: got 0x%02h, expected 0x%02h", rx_data, e);
                        end
                    end
                end
            end
        join_none

        // Reset
        tick(3);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_data_rdy", data_rdy, 0);
        check("reset_miso", spi_miso, 0);
        rst = 1'b0;
        tick(SS + 4);
        check("state_idle_after_reset", 32'(dut.state), 32'(S_IDLE));

        // Single byte + latency
        frame_start();
        send_byte(8'hA5, r);
        tick(2);
        check("single_rdy_count", rdy_cnt, 1);
        check("single_latency", rdy_cyc - rise_cyc, SS + 2);
        check("single_miso_reset_buf", r, 8'h00);
        frame_end();

        // Transmit
        csr_latch(8'h3C);
        frame_start();
        send_byte(8'h11, r);
        check("tx_3c", r, 8'h3C);
        frame_end();
        check("miso_deselected", spi_miso, 0);

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_latch) csr_latch(vecs[i].tx);
            frame_start();
            send_byte(vecs[i].mosi, r);
            check($sformatf("vec%0d_miso", i), r, vecs[i].exp_miso);
            frame_end();
        end

        // Burst: CSR latches 0x55 after the first byte of the frame
        csr_latch(8'h77);
        auto_val = 8'h55;
        auto_at  = rdy_cnt + 1;
        n0       = rdy_cnt;
        frame_start();
        send_byte(8'h81, r1);
        send_byte(8'h12, r2);
        send_byte(8'h34, r3);
        frame_end();
        check("burst_rdy_count", rdy_cnt - n0, 3);
        check("burst_miso0", r1, 8'h77);
        check("burst_miso1", r2, 8'h55);
        check("burst_miso2", r3, 8'h55);

        // Abort after 5 bits
        n0 = rdy_cnt;
        frame_start();
        spi_bits(8'hFF, 5, r);
        frame_end();
        check("abort_no_rdy", rdy_cnt, n0);
        frame_start();
        send_byte(8'h5A, r);
        frame_end();

        // Reset mid-frame
        n0 = rdy_cnt;
        frame_start();
        spi_bits(8'hFF, 4, r);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("state_wait_after_midframe_rst", 32'(dut.state), 32'(S_WAIT));
        spi_bits(8'h00, 4, r);
        check("miso_low_in_wait", r, 8'h00);
        tick(HALF);
        spi_cs_n = 1'b1;
        tick(2 * HALF);
        check("state_idle_after_cs_high", 32'(dut.state), 32'(S_IDLE));
        check("rst_frame_no_rdy", rdy_cnt, n0);
        frame_start();
        send_byte(8'hC3, r);
        frame_end();

        tick(4);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
